// File: rtl/cachepool_refill_responder_pkg.sv
// -----------------------------------------------------------------------------
// cachepool_refill_responder_pkg
// Shared types and widths for the CachePool refill responder:
//   - refill beat / L1 line / address widths
//   - cache_info_t : opaque tag echoed on every response
//   - burst_req_t  : burst qualifier (is_burst, burst_len = beats - 1)
//   - refill_rsp_state_e : responder FSM states
// -----------------------------------------------------------------------------
package cachepool_refill_responder_pkg;

  localparam int unsigned RefillAddrWidth = 32;
  localparam int unsigned RefillDataWidth = 128;
  localparam int unsigned L1LineWidth     = 512;

  // Wide enough to express every burst length that fits in one line.
  localparam int unsigned BurstLenWidth = $clog2(L1LineWidth / RefillDataWidth);

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] port;
  } cache_info_t;

  typedef struct packed {
    logic                     is_burst;
    logic [BurstLenWidth-1:0] burst_len;
  } burst_req_t;

  typedef enum logic [2:0] {
    RR_IDLE,
    RR_RD_MEM,
    RR_RD_CAP,
    RR_RD_SEND,
    RR_WR_COLLECT,
    RR_WR_MEM,
    RR_WR_ACK
  } refill_rsp_state_e;

endpackage

// File: rtl/cachepool_refill_responder_if.sv
// -----------------------------------------------------------------------------
// cachepool_refill_responder_if
// Refill channel between an L1 cache controller (master) and the memory-side
// responder (slave).
//   req_* : request  (valid/ready), address, tag, write beat, strobes, burst
//   rsp_* : response (valid/ready), write-ack flag, read beat, echoed tag
// -----------------------------------------------------------------------------
interface cachepool_refill_responder_if
  import cachepool_refill_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = RefillAddrWidth,
  parameter int unsigned BeatWidth = RefillDataWidth,
  parameter type         info_t    = cache_info_t
);

  logic                   req_valid;
  logic                   req_ready;
  logic [AddrWidth-1:0]   req_addr;
  info_t                  req_info;
  logic                   req_write;
  logic [BeatWidth-1:0]   req_wdata;
  logic [BeatWidth/8-1:0] req_wstrb;
  burst_req_t             req_burst;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [BeatWidth-1:0]   rsp_data;
  info_t                  rsp_info;

  modport master (
    output req_valid, req_addr, req_info, req_write, req_wdata, req_wstrb, req_burst,
    input  req_ready,
    input  rsp_valid, rsp_write, rsp_data, rsp_info,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_addr, req_info, req_write, req_wdata, req_wstrb, req_burst,
    output req_ready,
    output rsp_valid, rsp_write, rsp_data, rsp_info,
    input  rsp_ready
  );

endinterface

// File: rtl/cachepool_refill_responder.sv
// -----------------------------------------------------------------------------
// cachepool_refill_responder
// Memory-side responder for one L1 refill port, backed by a single-ported,
// line-wide L2 bank. Line reads go out as a wrapping burst of beats; write-back
// beats are gathered into one masked line write.
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   refill        : refill channel (slave modport)
//   mem_req_o     : bank request          mem_gnt_i   : bank grant
//   mem_we_o      : bank write enable     mem_addr_o  : line address
//   mem_wdata_o   : line write data       mem_be_o    : line byte enables
//   mem_rdata_i   : line read data, valid the cycle after a read grant
// -----------------------------------------------------------------------------
module cachepool_refill_responder
  import cachepool_refill_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = RefillAddrWidth,
  parameter int unsigned LineWidth = L1LineWidth,
  parameter int unsigned BeatWidth = RefillDataWidth,
  parameter type         info_t    = cache_info_t,
  localparam int unsigned NumBeats  = LineWidth / BeatWidth,
  localparam int unsigned BeatIdxW  = $clog2(NumBeats),
  localparam int unsigned LineOffW  = $clog2(LineWidth / 8),
  localparam int unsigned MemAddrW  = AddrWidth - LineOffW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  cachepool_refill_responder_if.slave refill,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_we_o,
  output logic [MemAddrW-1:0]    mem_addr_o,
  output logic [LineWidth-1:0]   mem_wdata_o,
  output logic [LineWidth/8-1:0] mem_be_o,
  input  logic [LineWidth-1:0]   mem_rdata_i
);

  localparam int unsigned BeatBytes = BeatWidth / 8;
  localparam int unsigned CntW      = BeatIdxW + 1;

  refill_rsp_state_e      r_state;
  logic                   r_req_ready;
  logic [MemAddrW-1:0]    r_mem_addr;
  info_t                  r_info;
  logic [BeatIdxW-1:0]    r_start;
  logic [CntW-1:0]        r_len;
  logic [CntW-1:0]        r_cnt;
  logic [LineWidth-1:0]   r_line;
  logic [LineWidth/8-1:0] r_be;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic                   r_rsp_valid;
  logic                   r_rsp_write;
  logic [BeatWidth-1:0]   r_rsp_data;

  logic                   w_req_fire;
  logic                   w_rsp_fire;
  logic [BeatIdxW-1:0]    w_req_start;
  logic [CntW-1:0]        w_req_len;
  logic [BeatIdxW-1:0]    w_wr_slot;
  logic [BeatIdxW-1:0]    w_rd_next_idx;
  logic [LineWidth-1:0]   w_line_merged;
  logic [LineWidth/8-1:0] w_be_merged;
  logic                   w_unused;

  // Ready is forced low while reset is held so nothing can handshake then,
  // yet it is already high in the very first cycle after reset releases.
  assign refill.req_ready = r_req_ready & ~rst_i;
  assign refill.rsp_valid = r_rsp_valid;
  assign refill.rsp_write = r_rsp_write;
  assign refill.rsp_data  = r_rsp_data;
  assign refill.rsp_info  = r_info;

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_line;
  assign mem_be_o    = r_be;

  assign w_req_fire = refill.req_valid & refill.req_ready;
  assign w_rsp_fire = r_rsp_valid & refill.rsp_ready;

  // Byte offset bits above the in-beat offset pick the starting beat.
  assign w_req_start = refill.req_addr[LineOffW-1 -: BeatIdxW];
  assign w_req_len   = refill.req_burst.is_burst ? CntW'(refill.req_burst.burst_len) : '0;

  // Beat positions wrap inside the line because the sum is BeatIdxW bits wide.
  assign w_wr_slot     = (r_state == RR_IDLE) ? w_req_start : r_start + r_cnt[BeatIdxW-1:0];
  assign w_rd_next_idx = r_start + r_cnt[BeatIdxW-1:0] + BeatIdxW'(1);

  // In-beat byte offset bits carry no meaning for a line-granular bank.
  assign w_unused = ^refill.req_addr[LineOffW-BeatIdxW-1:0];

  // Merge the incoming write beat into the line buffer. The first beat of a
  // write-back starts from an empty line so stale bytes never reach the bank.
  // NOTE: every always_comb output gets a full default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_line_merged = (r_state == RR_IDLE) ? '0 : r_line;
    w_be_merged   = (r_state == RR_IDLE) ? '0 : r_be;
    for (int b = 0; b < BeatBytes; b++) begin
      if (refill.req_wstrb[b]) begin
        w_line_merged[(int'(w_wr_slot) * BeatBytes + b) * 8 +: 8] = refill.req_wdata[b*8 +: 8];
        w_be_merged[int'(w_wr_slot) * BeatBytes + b]              = 1'b1;
      end
    end
  end

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RR_IDLE;
      r_req_ready <= 1'b1;
      r_mem_addr  <= '0;
      r_info      <= '0;
      r_start     <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      // NOTE: the line buffer and strobe register drive mem_wdata_o/mem_be_o
      // directly, so unlike a plain storage array they must be reset.
      r_line      <= '0;
      r_be        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        RR_IDLE: begin
          if (w_req_fire) begin
            r_mem_addr <= refill.req_addr[AddrWidth-1:LineOffW];
            r_info     <= refill.req_info;
            r_start    <= w_req_start;
            r_len      <= w_req_len;
            if (refill.req_write) begin
              r_line <= w_line_merged;
              r_be   <= w_be_merged;
              r_cnt  <= CntW'(1);
              if (w_req_len == '0) begin
                r_req_ready <= 1'b0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b1;
                r_state     <= RR_WR_MEM;
              end else begin
                r_state <= RR_WR_COLLECT;
              end
            end else begin
              r_be        <= '0;
              r_cnt       <= '0;
              r_req_ready <= 1'b0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b0;
              r_state     <= RR_RD_MEM;
            end
          end
        end

        RR_RD_MEM: begin
          if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= RR_RD_CAP;
          end
        end

        RR_RD_CAP: begin
          r_line      <= mem_rdata_i;
          r_rsp_data  <= mem_rdata_i[r_start*BeatWidth +: BeatWidth];
          r_rsp_valid <= 1'b1;
          r_rsp_write <= 1'b0;
          r_state     <= RR_RD_SEND;
        end

        RR_RD_SEND: begin
          if (w_rsp_fire) begin
            if (r_cnt == r_len) begin
              r_rsp_valid <= 1'b0;
              r_rsp_data  <= '0;
              r_req_ready <= 1'b1;
              r_state     <= RR_IDLE;
            end else begin
              r_cnt      <= r_cnt + CntW'(1);
              r_rsp_data <= r_line[w_rd_next_idx*BeatWidth +: BeatWidth];
            end
          end
        end

        RR_WR_COLLECT: begin
          if (w_req_fire) begin
            r_line <= w_line_merged;
            r_be   <= w_be_merged;
            r_cnt  <= r_cnt + CntW'(1);
            if (r_cnt == r_len) begin
              r_req_ready <= 1'b0;
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_state     <= RR_WR_MEM;
            end
          end
        end

        RR_WR_MEM: begin
          if (mem_gnt_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b1;
            r_rsp_data  <= '0;
            r_state     <= RR_WR_ACK;
          end
        end

        RR_WR_ACK: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= RR_IDLE;
          end
        end

        default: begin
          r_state <= RR_IDLE;
        end
      endcase
    end
  end

  // A read interleaved into an open write-back has no defined meaning.
  a_no_read_in_wr_collect: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (r_state == RR_WR_COLLECT && refill.req_valid) |-> refill.req_write
  );

endmodule
